// File: rtl/aib_rxfifo_wr_dpath.sv
// aib_rxfifo_wr_dpath
//   Write-side datapath of the adapter RX FIFO. Packs 80-bit receive dwords
//   into DWIDTH-wide entries according to the FIFO rate mode, owns the FIFO
//   storage flops, and keeps the binary/Gray write pointers plus full and
//   sticky-overflow status.
//
// Ports
//   wr_clk, wr_rst_n   write clock, async active-low reset
//   wr_en, wr_data     write strobe and 80-bit receive dword
//   r_fifo_mode        00 full, 01 half, 10 quarter, 11 treated as full rate
//   m_gen2_mode        1: 80 valid bits, 0: only low 40 bits valid
//   rd_ptr_bin_sync    read pointer already synchronised into wr_clk
//   fifo_data_async    storage array, read directly by the read side
//   wr_ptr_gray/_bin   registered write pointers (AWIDTH+1 bits)
//   fifo_full          combinational full flag
//   wr_ovf             sticky: write attempted while full
module aib_rxfifo_wr_dpath #(
  parameter int DWIDTH = 320,
  parameter int DEPTH  = 16,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic                           wr_clk,
  input  logic                           wr_rst_n,
  input  logic                           wr_en,
  input  logic [79:0]                    wr_data,
  input  logic [1:0]                     r_fifo_mode,
  input  logic                           m_gen2_mode,
  input  logic [AWIDTH:0]                rd_ptr_bin_sync,
  output logic [DEPTH-1:0][DWIDTH-1:0]   fifo_data_async,
  output logic [AWIDTH:0]                wr_ptr_gray,
  output logic [AWIDTH:0]                wr_ptr_bin,
  output logic                           fifo_full,
  output logic                           wr_ovf
);

  localparam int DW  = 80;
  localparam int NDW = DWIDTH / DW;

  typedef enum logic [1:0] {
    MODE_FULL    = 2'b00,
    MODE_HALF    = 2'b01,
    MODE_QUARTER = 2'b10,
    MODE_RSVD    = 2'b11
  } fifo_mode_e;

  logic [DEPTH-1:0][DWIDTH-1:0] mem_q;
  logic [AWIDTH:0]              wptr_bin_q, wptr_bin_d;
  logic [AWIDTH:0]              wptr_gray_q, wptr_gray_d;
  logic [1:0]                   phase_q, phase_d;
  logic [1:0]                   phase_lim;
  logic                         ovf_q, ovf_d;
  logic                         full, accept, commit;
  logic [DW-1:0]                wdata;
  logic [AWIDTH-1:0]            widx;
  fifo_mode_e                   mode;

  assign mode = fifo_mode_e'(r_fifo_mode);

  always_comb begin
    phase_lim = 2'd0;
    case (mode)
      MODE_HALF:    phase_lim = 2'd1;
      MODE_QUARTER: phase_lim = 2'd3;
      default:      phase_lim = 2'd0;
    endcase
  end

  // Full: same entry index, opposite lap.
  assign full   = (wptr_bin_q[AWIDTH] != rd_ptr_bin_sync[AWIDTH]) &&
                  (wptr_bin_q[AWIDTH-1:0] == rd_ptr_bin_sync[AWIDTH-1:0]);
  assign accept = wr_en & ~full;
  // >= rather than == so a mode change mid-entry commits on the next write.
  assign commit = accept & (phase_q >= phase_lim);
  assign widx   = wptr_bin_q[AWIDTH-1:0];
  assign wdata  = m_gen2_mode ? wr_data : {{(DW/2){1'b0}}, wr_data[DW/2-1:0]};

  always_comb begin
    phase_d     = phase_q;
    wptr_bin_d  = wptr_bin_q;
    wptr_gray_d = wptr_gray_q;
    ovf_d       = ovf_q | (wr_en & full);
    if (commit) begin
      phase_d     = '0;
      wptr_bin_d  = wptr_bin_q + {{AWIDTH{1'b0}}, 1'b1};
      wptr_gray_d = wptr_bin_d ^ (wptr_bin_d >> 1);
    end else if (accept) begin
      phase_d     = phase_q + 2'd1;
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      mem_q       <= '0;
      wptr_bin_q  <= '0;
      wptr_gray_q <= '0;
      phase_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wptr_bin_q  <= wptr_bin_d;
      wptr_gray_q <= wptr_gray_d;
      phase_q     <= phase_d;
      ovf_q       <= ovf_d;
      if (accept) begin
        for (int unsigned i = 0; i < NDW; i++) begin
          if (phase_q == 2'(i)) begin
            mem_q[widx][i*DW +: DW] <= wdata;
          end
        end
      end
    end
  end

  assign fifo_data_async = mem_q;
  assign wr_ptr_bin      = wptr_bin_q;
  assign wr_ptr_gray     = wptr_gray_q;
  assign fifo_full       = full;
  assign wr_ovf          = ovf_q;

endmodule

// File: tb/tb_aib_rxfifo_wr_dpath.sv
module tb_aib_rxfifo_wr_dpath;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DWID  = 320;
  localparam int PW    = AW + 1;
  localparam int M     = 2 * DEPTH;

  logic                        wr_clk = 1'b0;
  logic                        wr_rst_n;
  logic                        wr_en;
  logic [79:0]                 wr_data;
  logic [1:0]                  r_fifo_mode;
  logic                        m_gen2_mode;
  logic [PW-1:0]               rd_ptr_bin_sync;
  logic [DEPTH-1:0][DWID-1:0]  fifo_data_async;
  logic [PW-1:0]               wr_ptr_gray;
  logic [PW-1:0]               wr_ptr_bin;
  logic                        fifo_full;
  logic                        wr_ovf;

  always #5 wr_clk = ~wr_clk;

  aib_rxfifo_wr_dpath #(.DWIDTH(DWID), .DEPTH(DEPTH), .AWIDTH(AW)) dut (
    .wr_clk          (wr_clk),
    .wr_rst_n        (wr_rst_n),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .r_fifo_mode     (r_fifo_mode),
    .m_gen2_mode     (m_gen2_mode),
    .rd_ptr_bin_sync (rd_ptr_bin_sync),
    .fifo_data_async (fifo_data_async),
    .wr_ptr_gray     (wr_ptr_gray),
    .wr_ptr_bin      (wr_ptr_bin),
    .fifo_full       (fifo_full),
    .wr_ovf          (wr_ovf)
  );

  // Reference model: entries as arrays of dwords, pointer as a commit count.
  logic [79:0]   m_mem [DEPTH][4];
  int            m_wp, m_phase, m_rd;
  bit            m_ovf;
  logic [PW-1:0] prev_gray;
  int            vectors = 0;
  int            miscompares = 0;

  function automatic int occupancy();
    return (m_wp - m_rd + M) % M;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    logic [DEPTH-1:0][DWID-1:0] exp;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < 4; j++)
        exp[i][j*80 +: 80] = m_mem[i][j];
    vectors++;
    assert (fifo_data_async === exp) else begin
      miscompares++;
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_data_async[i] !== exp[i]) begin
          $error("FAIL %s: entry %0d observed %h expected %h", tag, i, fifo_data_async[i], exp[i]);
          break;
        end
      end
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_bin"},  320'(wr_ptr_bin),  320'(m_wp));
    chk({tag, "_gray"}, 320'(wr_ptr_gray), 320'(m_wp ^ (m_wp >> 1)));
    chk({tag, "_full"}, 320'(fifo_full),   320'(occupancy() == DEPTH));
    chk({tag, "_ovf"},  320'(wr_ovf),      320'(m_ovf));
    chk({tag, "_graystep"}, 320'($countones(wr_ptr_gray ^ prev_gray) <= 1), 320'(1));
    chk_mem({tag, "_mem"});
    prev_gray = wr_ptr_gray;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < 4; j++)
        m_mem[i][j] = '0;
    m_wp = 0; m_phase = 0; m_rd = 0; m_ovf = 0;
    prev_gray = '0;
  endtask

  task automatic model_write(input logic [79:0] d);
    int lim;
    if (occupancy() == DEPTH) begin
      m_ovf = 1;
      return;
    end
    lim = (r_fifo_mode == 2'd1) ? 1 : (r_fifo_mode == 2'd2) ? 3 : 0;
    m_mem[m_wp % DEPTH][m_phase] = m_gen2_mode ? d : (d & 80'hFF_FFFF_FFFF);
    if (m_phase >= lim) begin
      m_phase = 0;
      m_wp = (m_wp + 1) % M;
    end else begin
      m_phase++;
    end
  endtask

  // Called one time unit after a rising edge; returns the same.
  task automatic step(input bit en, input logic [79:0] d, input string tag);
    wr_en = en;
    wr_data = d;
    rd_ptr_bin_sync = PW'(m_rd);
    @(posedge wr_clk);
    if (en) model_write(d);
    #1;
    wr_en = 1'b0;
    chk_all(tag);
  endtask

  // Asserts reset mid-cycle, checks outputs clear before any edge, releases mid-cycle.
  task automatic do_reset(input string tag);
    @(negedge wr_clk);
    wr_rst_n = 1'b0;
    #1;
    model_reset();
    rd_ptr_bin_sync = '0;
    #1;
    chk({tag, "_rbin"},  320'(wr_ptr_bin),  320'(0));
    chk({tag, "_rovf"},  320'(wr_ovf),      320'(0));
    chk_all(tag);
    @(posedge wr_clk);
    #2;
    wr_rst_n = 1'b1;
    @(posedge wr_clk);
    #1;
  endtask

  initial begin
    logic [79:0] a, b, c, dd, ones;
    bit saw_wrap;
    wr_rst_n = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    r_fifo_mode = 2'b00;
    m_gen2_mode = 1'b1;
    rd_ptr_bin_sync = '0;
    model_reset();
    do_reset("reset");

    // Full rate fill to full, then overflow attempt.
    for (int k = 0; k < DEPTH; k++) step(1'b1, 80'(k + 1), "t1_fill");
    chk("t1_bin16", 320'(wr_ptr_bin), 320'(16));
    chk("t1_full",  320'(fifo_full),  320'(1));
    step(1'b1, 80'h77, "t1_ovf");
    chk("t1_ovf_set",  320'(wr_ovf), 320'(1));
    chk("t1_e0_hold",  320'(fifo_data_async[0][79:0]), 320'(1));

    // Reader frees an entry on the same cycle as a write.
    m_rd = 1;
    step(1'b1, 80'hABC, "t4");
    chk("t4_bin",  320'(wr_ptr_bin),  320'(5'b10001));
    chk("t4_gray", 320'(wr_ptr_gray), 320'(5'b11001));
    chk("t4_e0",   320'(fifo_data_async[0][79:0]), 320'(80'hABC));

    // Reader tracking, pointer wraps.
    saw_wrap = 0;
    for (int k = 0; k < 40; k++) begin
      m_rd = m_wp;
      step(1'b1, 80'(k * 3 + 5), "t5");
      if (wr_ptr_bin == '0) saw_wrap = 1;
    end
    chk("t5_wrap", 320'(saw_wrap), 320'(1));

    // Half rate packing.
    do_reset("t2_rst");
    r_fifo_mode = 2'b01;
    a = 80'h1111_2222_3333_4444_5555;
    b = 80'h6666_7777_8888_9999_AAAA;
    c = 80'hBBBB_CCCC_DDDD_EEEE_FFFF;
    dd = 80'h0123_4567_89AB_CDEF_0123;
    step(1'b1, a, "t2_a");
    chk("t2_bin_a", 320'(wr_ptr_bin), 320'(0));
    step(1'b1, b, "t2_b");
    chk("t2_bin_b", 320'(wr_ptr_bin), 320'(1));
    chk("t2_e0",    320'(fifo_data_async[0][159:0]), 320'({b, a}));
    step(1'b1, c, "t2_c");
    chk("t2_gray_c", 320'(wr_ptr_gray), 320'(1));
    step(1'b1, dd, "t2_d");
    chk("t2_e1",    320'(fifo_data_async[1][159:0]), 320'({dd, c}));

    // Quarter rate Gen1 masking.
    do_reset("t3_rst");
    r_fifo_mode = 2'b10;
    m_gen2_mode = 1'b0;
    ones = '1;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, ones, "t3");
      chk("t3_bin", 320'(wr_ptr_bin), 320'(k == 3 ? 1 : 0));
    end
    for (int j = 0; j < 4; j++)
      chk("t3_dw", 320'(fifo_data_async[0][j*80 +: 80]), 320'(80'h00000000FFFFFFFFFF));

    // Reset mid-entry discards the partial entry.
    do_reset("t6_rst0");
    m_gen2_mode = 1'b1;
    step(1'b1, 80'hAAAA, "t6_w");
    step(1'b1, 80'hBBBB, "t6_w");
    do_reset("t6_rst");
    step(1'b1, 80'h1234, "t6_after");
    chk("t6_e0", 320'(fifo_data_async[0][159:0]), 320'({80'h0, 80'h1234}));

    // Randomized traffic with lagging reader and mode changes.
    do_reset("rnd_rst");
    r_fifo_mode = 2'b00;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(15) == 0) r_fifo_mode = 2'($urandom);
      if ($urandom_range(7) == 0)  m_gen2_mode = 1'($urandom);
      if ($urandom_range(2) == 0 && occupancy() > 0) m_rd = (m_rd + 1) % M;
      step($urandom_range(3) != 0, {16'($urandom), $urandom, $urandom}, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
